// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: main control FSM of the multi-cycle MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB over the shared datapath and unified memory.
// Inputs : clk, rst (async, active-high), opcode_i/funct_i (IR fields), zero_i (ALU flag),
//          mem_ready_i (memory completes the current access).
// Outputs: memory strobes (mem_req_o, mem_we_o, iord_o), datapath selects and enables,
//          alu_ctrl_o, pc_source_o, state_o, and event pulses instr_done_o/illegal_o/mem_err_o.
module mc_ctrl_fsm #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic       ext_op_o,
    output logic [2:0] alu_ctrl_o,
    output logic [1:0] pc_source_o,
    output logic [3:0] state_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic       mem_err_o
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC,
        S_RWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP, S_JR
    } state_t;
    localparam int CW = WAIT_MAX > 1 ? $clog2(WAIT_MAX) : 1;
    state_t state_q, state_d;
    logic [CW-1:0] wait_q;
    logic req, waiting, timeout, r_ok, dec_ok, is_shift;
    logic [2:0] r_alu;
    assign req      = state_q inside {S_FETCH, S_MEMRD, S_MEMWR};
    assign waiting  = req && !mem_ready_i;
    // Timeout fires on the WAIT_MAX-th consecutive unanswered cycle.
    assign timeout  = (WAIT_MAX != 0) && waiting && (wait_q == CW'(WAIT_MAX - 1));
    assign r_ok     = funct_i inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
    assign is_shift = funct_i inside {6'h00, 6'h02};
    assign r_alu    = funct_i == 6'h22 ? 3'd1 : funct_i == 6'h24 ? 3'd2 : funct_i == 6'h25 ? 3'd3 :
                      funct_i == 6'h2A ? 3'd4 : funct_i == 6'h00 ? 3'd5 : funct_i == 6'h02 ? 3'd6 : 3'd0;
    assign dec_ok   = opcode_i == 6'h00 ? (r_ok || funct_i == 6'h08) :
                      opcode_i inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    assign state_o  = state_q;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: state_d = !dec_ok ? S_FETCH :
                                opcode_i == 6'h00 ? (funct_i == 6'h08 ? S_JR : S_REXEC) :
                                opcode_i inside {6'h23, 6'h2B} ? S_MEMADR :
                                opcode_i inside {6'h04, 6'h05} ? S_BRANCH :
                                opcode_i inside {6'h02, 6'h03} ? S_JUMP : S_IEXEC;
            S_MEMADR: state_d = opcode_i == 6'h2B ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
            S_REXEC:  state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
        if (timeout) state_d = S_FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= (state_d != state_q || timeout) ? '0 : waiting ? wait_q + CW'(1) : wait_q;
        end
    end

    always_comb begin
        mem_req_o    = req;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 2'd0;
        mem_to_reg_o = 2'd0;
        alu_src_a_o  = 2'd0;
        alu_src_b_o  = 2'd0;
        ext_op_o     = 1'b0;
        alu_ctrl_o   = 3'd0;
        pc_source_o  = 2'd0;
        case (state_q)
            S_FETCH: begin
                alu_src_b_o = 2'd1;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o = 2'd3;
                ext_op_o    = 1'b1;
            end
            S_MEMADR: begin
                alu_src_a_o = 2'd1;
                alu_src_b_o = 2'd2;
                ext_op_o    = 1'b1;
            end
            S_MEMRD: iord_o = 1'b1;
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'd1;
            end
            S_MEMWR: begin
                iord_o   = 1'b1;
                mem_we_o = 1'b1;
            end
            S_REXEC: begin
                alu_src_a_o = is_shift ? 2'd2 : 2'd1;
                alu_ctrl_o  = r_alu;
            end
            S_RWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 2'd1;
            end
            S_BRANCH: begin
                alu_src_a_o = 2'd1;
                alu_ctrl_o  = 3'd1;
                pc_source_o = 2'd1;
                pc_write_o  = opcode_i == 6'h04 ? zero_i : !zero_i;
            end
            S_IEXEC: begin
                alu_src_a_o = 2'd1;
                alu_src_b_o = 2'd2;
                ext_op_o    = opcode_i inside {6'h08, 6'h0A};
                alu_ctrl_o  = opcode_i == 6'h0A ? 3'd4 : opcode_i == 6'h0C ? 3'd2 :
                              opcode_i == 6'h0D ? 3'd3 : opcode_i == 6'h0F ? 3'd7 : 3'd0;
            end
            S_IWB: reg_write_o = 1'b1;
            S_JUMP: begin
                pc_write_o   = 1'b1;
                pc_source_o  = 2'd2;
                reg_write_o  = opcode_i == 6'h03;
                reg_dst_o    = opcode_i == 6'h03 ? 2'd2 : 2'd0;
                mem_to_reg_o = opcode_i == 6'h03 ? 2'd2 : 2'd0;
            end
            S_JR: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'd3;
            end
            default: ;
        endcase
        // Write strobes must drop the instant reset asserts, independent of the clock.
        if (rst) begin
            ir_write_o  = 1'b0;
            pc_write_o  = 1'b0;
            reg_write_o = 1'b0;
            mem_we_o    = 1'b0;
        end
    end

    assign illegal_o    = !rst && state_q == S_DECODE && !dec_ok;
    assign mem_err_o    = !rst && timeout;
    assign instr_done_o = !rst && (state_q inside {S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP, S_JR} ||
                                   (state_q == S_MEMWR && mem_ready_i));
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven scoreboard bench for mc_ctrl_fsm.
module tb_mc_ctrl_fsm;
    logic clk = 1'b0, rst = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic zero = 1'b0, mem_ready = 1'b0;
    logic mem_req, mem_we, iord, ir_write, pc_write, reg_write, ext_op, instr_done, illegal, mem_err;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
    int pass_cnt = 0, tot_cnt = 0;

    mc_ctrl_fsm #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we), .iord_o(iord),
        .ir_write_o(ir_write), .pc_write_o(pc_write), .reg_write_o(reg_write),
        .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a),
        .alu_src_b_o(alu_src_b), .ext_op_o(ext_op), .alu_ctrl_o(alu_ctrl),
        .pc_source_o(pc_source), .state_o(state), .instr_done_o(instr_done),
        .illegal_o(illegal), .mem_err_o(mem_err)
    );

    always #5 clk = ~clk;

    logic [26:0] act;
    assign act = {state, mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, ext_op, alu_ctrl, pc_source, instr_done, illegal, mem_err};

    // f = {mem_req, mem_we, iord, ir_write, pc_write, reg_write}; ev = {instr_done, illegal, mem_err}
    function automatic logic [26:0] ex(int st, logic [5:0] f, int dst, int mtr, int sa, int sb,
                                       int ext, int alu, int ps, logic [2:0] ev);
        return {4'(st), f, 2'(dst), 2'(mtr), 2'(sa), 2'(sb), 1'(ext), 3'(alu), 2'(ps), ev};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        r;
        logic [26:0] e;
    } vec_t;

    vec_t tbl[$];
    logic [26:0] exp_q[$];

    task automatic check(input string nm, input logic [26:0] e);
        tot_cnt++;
        if (act === e) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (state got %0d exp %0d)", nm, act, e, act[26:23], e[26:23]);
    endtask

    task automatic step(input string nm, input vec_t v);
        opcode = v.op; funct = v.fn; zero = v.z; mem_ready = v.r;
        exp_q.push_back(v.e);
        @(negedge clk);
        check(nm, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic r,
                       input logic [26:0] e);
        tbl.push_back('{op, fn, z, r, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [26:0] fet1, fet0, dec;
        fet1 = ex(0, 6'b100110, 0, 0, 0, 1, 0, 0, 0, 3'b000);
        fet0 = ex(0, 6'b100000, 0, 0, 0, 1, 0, 0, 0, 3'b000);
        dec  = ex(1, 6'b000000, 0, 0, 0, 3, 1, 0, 0, 3'b000);
        // addi
        add(6'h08, 0, 0, 1, fet1);
        add(6'h08, 0, 0, 1, dec);
        add(6'h08, 0, 0, 1, ex(9, 6'b000000, 0, 0, 1, 2, 1, 0, 0, 3'b000));
        add(6'h08, 0, 0, 1, ex(10, 6'b000001, 0, 0, 0, 0, 0, 0, 0, 3'b100));
        // lw with two wait cycles in MEMRD
        add(6'h23, 0, 0, 1, fet1);
        add(6'h23, 0, 0, 1, dec);
        add(6'h23, 0, 0, 1, ex(2, 6'b000000, 0, 0, 1, 2, 1, 0, 0, 3'b000));
        add(6'h23, 0, 0, 0, ex(3, 6'b101000, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        add(6'h23, 0, 0, 0, ex(3, 6'b101000, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        add(6'h23, 0, 0, 1, ex(3, 6'b101000, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        add(6'h23, 0, 0, 1, ex(4, 6'b000001, 0, 1, 0, 0, 0, 0, 0, 3'b100));
        // beq taken, with a fetch wait cycle
        add(6'h04, 0, 1, 0, fet0);
        add(6'h04, 0, 1, 1, fet1);
        add(6'h04, 0, 1, 1, dec);
        add(6'h04, 0, 1, 1, ex(8, 6'b000010, 0, 0, 1, 0, 0, 1, 1, 3'b100));
        // bne with zero=1: not taken
        add(6'h05, 0, 1, 1, fet1);
        add(6'h05, 0, 1, 1, dec);
        add(6'h05, 0, 1, 1, ex(8, 6'b000000, 0, 0, 1, 0, 0, 1, 1, 3'b100));
        // jal
        add(6'h03, 0, 0, 1, fet1);
        add(6'h03, 0, 0, 1, dec);
        add(6'h03, 0, 0, 1, ex(11, 6'b000011, 2, 2, 0, 0, 0, 0, 2, 3'b100));
        // j
        add(6'h02, 0, 0, 1, fet1);
        add(6'h02, 0, 0, 1, dec);
        add(6'h02, 0, 0, 1, ex(11, 6'b000010, 0, 0, 0, 0, 0, 0, 2, 3'b100));
        // R sub
        add(6'h00, 6'h22, 0, 1, fet1);
        add(6'h00, 6'h22, 0, 1, dec);
        add(6'h00, 6'h22, 0, 1, ex(6, 6'b000000, 0, 0, 1, 0, 0, 1, 0, 3'b000));
        add(6'h00, 6'h22, 0, 1, ex(7, 6'b000001, 1, 0, 0, 0, 0, 0, 0, 3'b100));
        // R srl uses shamt
        add(6'h00, 6'h02, 0, 1, fet1);
        add(6'h00, 6'h02, 0, 1, dec);
        add(6'h00, 6'h02, 0, 1, ex(6, 6'b000000, 0, 0, 2, 0, 0, 6, 0, 3'b000));
        add(6'h00, 6'h02, 0, 1, ex(7, 6'b000001, 1, 0, 0, 0, 0, 0, 0, 3'b100));
        // jr
        add(6'h00, 6'h08, 0, 1, fet1);
        add(6'h00, 6'h08, 0, 1, dec);
        add(6'h00, 6'h08, 0, 1, ex(12, 6'b000010, 0, 0, 0, 0, 0, 0, 3, 3'b100));
        // illegal opcode 3F, then back in FETCH
        add(6'h3F, 0, 0, 1, fet1);
        add(6'h3F, 0, 0, 1, ex(1, 6'b000000, 0, 0, 0, 3, 1, 0, 0, 3'b010));
        add(6'h3F, 0, 0, 0, fet0);
        // illegal R funct 0x3F
        add(6'h00, 6'h3F, 0, 1, fet1);
        add(6'h00, 6'h3F, 0, 1, ex(1, 6'b000000, 0, 0, 0, 3, 1, 0, 0, 3'b010));
        // ori zero-extends, slti sign-extends, lui
        add(6'h0D, 0, 0, 1, fet1);
        add(6'h0D, 0, 0, 1, dec);
        add(6'h0D, 0, 0, 1, ex(9, 6'b000000, 0, 0, 1, 2, 0, 3, 0, 3'b000));
        add(6'h0D, 0, 0, 1, ex(10, 6'b000001, 0, 0, 0, 0, 0, 0, 0, 3'b100));
        add(6'h0A, 0, 0, 1, fet1);
        add(6'h0A, 0, 0, 1, dec);
        add(6'h0A, 0, 0, 1, ex(9, 6'b000000, 0, 0, 1, 2, 1, 4, 0, 3'b000));
        add(6'h0A, 0, 0, 1, ex(10, 6'b000001, 0, 0, 0, 0, 0, 0, 0, 3'b100));
        add(6'h0F, 0, 0, 1, fet1);
        add(6'h0F, 0, 0, 1, dec);
        add(6'h0F, 0, 0, 1, ex(9, 6'b000000, 0, 0, 1, 2, 0, 7, 0, 3'b000));
        add(6'h0F, 0, 0, 1, ex(10, 6'b000001, 0, 0, 0, 0, 0, 0, 0, 3'b100));
        // sw with one wait cycle
        add(6'h2B, 0, 0, 1, fet1);
        add(6'h2B, 0, 0, 1, dec);
        add(6'h2B, 0, 0, 1, ex(2, 6'b000000, 0, 0, 1, 2, 1, 0, 0, 3'b000));
        add(6'h2B, 0, 0, 0, ex(5, 6'b111000, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        add(6'h2B, 0, 0, 1, ex(5, 6'b111000, 0, 0, 0, 0, 0, 0, 0, 3'b100));

        // Reset state: write strobes forced low even with mem_ready high.
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", fet0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

        // sw timeout: 14 quiet wait cycles, mem_err on the 15th, then FETCH.
        step("to_fetch", '{6'h2B, 0, 0, 1, fet1});
        step("to_dec", '{6'h2B, 0, 0, 1, dec});
        step("to_adr", '{6'h2B, 0, 0, 1, ex(2, 6'b000000, 0, 0, 1, 2, 1, 0, 0, 3'b000)});
        for (int k = 1; k < 15; k++)
            step($sformatf("to_wait%0d", k), '{6'h2B, 0, 0, 0, ex(5, 6'b111000, 0, 0, 0, 0, 0, 0, 0, 3'b000)});
        step("to_err", '{6'h2B, 0, 0, 0, ex(5, 6'b111000, 0, 0, 0, 0, 0, 0, 0, 3'b001)});
        step("to_after", '{6'h2B, 0, 0, 0, fet0});

        // Async reset in the middle of a MEMWR wait cycle.
        step("rs_fetch", '{6'h2B, 0, 0, 1, fet1});
        step("rs_dec", '{6'h2B, 0, 0, 1, dec});
        step("rs_adr", '{6'h2B, 0, 0, 1, ex(2, 6'b000000, 0, 0, 1, 2, 1, 0, 0, 3'b000)});
        step("rs_wait", '{6'h2B, 0, 0, 0, ex(5, 6'b111000, 0, 0, 0, 0, 0, 0, 0, 3'b000)});
        mem_ready = 1'b0;
        #1;
        check("rs_pre", ex(5, 6'b111000, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        rst = 1'b1;
        #1;
        check("rs_async", fet0);
        mem_ready = 1'b1;
        #1;
        check("rs_ready", fet0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("rs_re_fetch", '{6'h08, 0, 0, 1, fet1});
        step("rs_re_dec", '{6'h08, 0, 0, 1, dec});

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
